// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the shared-multiplier round-robin scheduler.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } arb_state_t;

  localparam int NREQ_DEF    = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int MUL_LAT_DEF = 2;
  localparam int MAX_OUT_DEF = 3;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: grants the first eligible index at or after the pointer.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = id_width(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_elig,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0]    r_ptr;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;
  logic              w_found;
  logic [IDW:0]      w_sum;
  logic [IDW-1:0]    w_ptr_nxt;

  // Rotate eligibility so that bit 0 corresponds to the pointer position.
  assign w_dbl = {i_elig, i_elig} >> r_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IDW'(k);
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign o_idx     = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : w_sum[IDW-1:0];
  assign o_any     = w_found;
  assign o_grant   = w_found ? (NREQ'(1) << o_idx) : '0;
  assign w_ptr_nxt = (o_idx == IDW'(NREQ - 1)) ? '0 : o_idx + IDW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters with per-requester credits,
// an id tag pipeline matched to the multiplier latency, and a drain/idle mode.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF,
  localparam int IDW    = id_width(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic [WIDTH-1:0]      o_mul_a,
  output logic [WIDTH-1:0]      o_mul_b,
  input  logic [2*WIDTH-1:0]    i_mul_m,
  output logic                  o_rsp_valid,
  output logic [IDW-1:0]        o_rsp_id,
  output logic [2*WIDTH-1:0]    o_rsp_m,
  input  logic                  i_drain_req,
  output logic                  o_idle
);

  localparam int CW = $clog2(MAX_OUT + 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [CW-1:0]      r_cnt [NREQ];
  logic [MUL_LAT-1:0] r_tag_vld;
  logic [IDW-1:0]     r_tag_id [MUL_LAT];
  logic               r_rsp_valid;
  logic [IDW-1:0]     r_rsp_id;
  logic [2*WIDTH-1:0] r_rsp_m;

  logic [NREQ-1:0]    w_elig;
  logic [NREQ-1:0]    w_grant;
  logic [IDW-1:0]     w_gidx;
  logic               w_any;
  logic               w_busy;
  logic               w_ret;
  logic [NREQ-1:0]    w_ret_oh;

  // Grants are suppressed while reset is held so req_ready reads zero.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = i_req_valid[i] && (r_cnt[i] < CW'(MAX_OUT)) &&
                  (r_state == RUN) && !i_rst;
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_elig  (w_elig),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign o_req_ready = w_grant;

  always_comb begin
    o_mul_a = '0;
    o_mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        o_mul_a = i_req_a[i*WIDTH +: WIDTH];
        o_mul_b = i_req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_cnt[i] != '0) w_busy = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // A drain that loses drain_req midway still finishes before returning to RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (i_drain_req) w_state_nxt = DRAIN;
      DRAIN:   if (!w_busy)     w_state_nxt = IDLE;
      IDLE:    if (!i_drain_req) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  assign o_idle = (r_state == IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      for (int s = 0; s < MUL_LAT; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_vld[0] <= w_any;
      r_tag_id[0]  <= w_gidx;
      for (int s = 1; s < MUL_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  assign w_ret    = r_tag_vld[MUL_LAT-1];
  assign w_ret_oh = w_ret ? (NREQ'(1) << r_tag_id[MUL_LAT-1]) : '0;

  // The last tag stage lines up with the product on i_mul_m.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_m     <= '0;
    end else begin
      r_rsp_valid <= w_ret;
      if (w_ret) begin
        r_rsp_id <= r_tag_id[MUL_LAT-1];
        r_rsp_m  <= i_mul_m;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_m     = r_rsp_m;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant[i] && !w_ret_oh[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (!w_grant[i] && w_ret_oh[i]) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
    end
  end

endmodule
